// File: rtl/game_pkg.sv
// Shared definitions for the Sokoban game datapath: command encodings and state width.
package game_pkg;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_PUSH = 2'd1;
  localparam logic [1:0] CMD_UNDO = 2'd2;
  localparam logic [1:0] CMD_REDO = 2'd3;

  localparam int unsigned GAME_STATE_W = 134;

endpackage

// File: rtl/game_hist_ptr.sv
// History pointer and undo/redo counters for game_undo_stack; decides accept/reject.
// Redo support is compiled in only when GAME_UNDO_REDO_EN is defined.
module game_hist_ptr
  import game_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_en_i,
  input  logic [1:0]      cmd_i,
  output logic            wr_en_o,
  output logic            wr_push_o,
  output logic [CntW-1:0] wr_idx_o,
  output logic            rd_en_o,
  output logic [CntW-1:0] rd_idx_o,
  output logic [CntW-1:0] undo_cnt_o,
  output logic [CntW-1:0] redo_cnt_o,
  output logic            cmd_err_o
);

  logic [CntW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CntW-1:0] undo_q, undo_d;
  logic            err_q, err_d;

  // Ring has DEPTH+1 slots, so wrap is explicit rather than modulo 2^CntW.
  assign ptr_inc = (ptr_q == CntW'(DEPTH)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? CntW'(DEPTH) : ptr_q - 1'b1;

`ifdef GAME_UNDO_REDO_EN
  logic [CntW-1:0] redo_q, redo_d;
`endif

  always_comb begin
    ptr_d     = ptr_q;
    undo_d    = undo_q;
    err_d     = 1'b0;
    wr_en_o   = 1'b0;
    wr_push_o = 1'b0;
    wr_idx_o  = ptr_q;
    rd_en_o   = 1'b0;
    rd_idx_o  = ptr_dec;
`ifdef GAME_UNDO_REDO_EN
    redo_d    = redo_q;
`endif
    if (cmd_en_i) begin
      unique case (cmd_i)
        CMD_LOAD: begin
          wr_en_o = 1'b1;
          undo_d  = '0;
`ifdef GAME_UNDO_REDO_EN
          redo_d  = '0;
`endif
        end
        CMD_PUSH: begin
          wr_en_o   = 1'b1;
          wr_push_o = 1'b1;
          wr_idx_o  = ptr_inc;
          ptr_d     = ptr_inc;
          // Saturate: the oldest entry is overwritten silently once full.
          undo_d    = (undo_q == CntW'(DEPTH)) ? undo_q : undo_q + 1'b1;
`ifdef GAME_UNDO_REDO_EN
          redo_d    = '0;
`endif
        end
        CMD_UNDO: begin
          if (undo_q != '0) begin
            ptr_d    = ptr_dec;
            rd_en_o  = 1'b1;
            rd_idx_o = ptr_dec;
            undo_d   = undo_q - 1'b1;
`ifdef GAME_UNDO_REDO_EN
            redo_d   = redo_q + 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_REDO: begin
`ifdef GAME_UNDO_REDO_EN
          if (redo_q != '0) begin
            ptr_d    = ptr_inc;
            rd_en_o  = 1'b1;
            rd_idx_o = ptr_inc;
            redo_d   = redo_q - 1'b1;
            undo_d   = undo_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      undo_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      undo_q <= undo_d;
      err_q  <= err_d;
    end
  end

`ifdef GAME_UNDO_REDO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redo_q <= '0;
    end else begin
      redo_q <= redo_d;
    end
  end
  assign redo_cnt_o = redo_q;
`else
  assign redo_cnt_o = '0;
`endif

  assign undo_cnt_o = undo_q;
  assign cmd_err_o  = err_q;

endmodule

// File: rtl/game_undo_stack.sv
// N-level undo history for the Sokoban game state: ring of DEPTH+1 state words.
// Optional redo enabled by defining GAME_UNDO_REDO_EN.
module game_undo_stack
  import game_pkg::*;
#(
  parameter int unsigned WIDTH = GAME_STATE_W,
  parameter int unsigned DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_en_i,
  input  logic [1:0]       cmd_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] state_out_o,
  output logic [CntW-1:0]  undo_cnt_o,
  output logic [CntW-1:0]  redo_cnt_o,
  output logic             cmd_err_o
);

  logic             wr_en, wr_push, rd_en;
  logic [CntW-1:0]  wr_idx, rd_idx;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] ring_q [DEPTH+1];
  logic [WIDTH-1:0] state_q;

  game_hist_ptr #(
    .DEPTH (DEPTH)
  ) u_hist_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_en_i   (cmd_en_i),
    .cmd_i      (cmd_i),
    .wr_en_o    (wr_en),
    .wr_push_o  (wr_push),
    .wr_idx_o   (wr_idx),
    .rd_en_o    (rd_en),
    .rd_idx_o   (rd_idx),
    .undo_cnt_o (undo_cnt_o),
    .redo_cnt_o (redo_cnt_o),
    .cmd_err_o  (cmd_err_o)
  );

  assign wr_data = wr_push ? push_data_i : load_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(DEPTH); i++) ring_q[i] <= RESET_VAL;
    end else if (wr_en) begin
      for (int i = 0; i <= int'(DEPTH); i++) begin
        if (wr_idx == CntW'(i)) ring_q[i] <= wr_data;
      end
    end
  end

  // Mirror of ring[ptr] kept as its own register so state_out has no read mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VAL;
    end else if (wr_en) begin
      state_q <= wr_data;
    end else if (rd_en) begin
      state_q <= ring_q[rd_idx];
    end
  end

  assign state_out_o = state_q;

endmodule

// File: tb/tb_game_undo_stack.sv
// Scoreboard bench for game_undo_stack: queue-based history model, directed and random commands.
module tb_game_undo_stack;
  import game_pkg::*;

  localparam int unsigned W     = GAME_STATE_W;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [W-1:0] RV   = '0;

  typedef logic [W-1:0] st_t;
  typedef struct {
    st_t         st;
    int unsigned uc;
    int unsigned rc;
    bit          err;
  } exp_t;

  logic          clk, rst_n, cmd_en;
  logic [1:0]    cmd;
  st_t           load_data, push_data, state_out;
  logic [CW-1:0] undo_cnt, redo_cnt;
  logic          cmd_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t sb[$];
  st_t  hist[$];  // oldest first, current state last
  st_t  fut[$];   // undone states, most recently undone last

  game_undo_stack #(
    .WIDTH     (W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_en_i    (cmd_en),
    .cmd_i       (cmd),
    .load_data_i (load_data),
    .push_data_i (push_data),
    .state_out_o (state_out),
    .undo_cnt_o  (undo_cnt),
    .redo_cnt_o  (redo_cnt),
    .cmd_err_o   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input st_t act, input st_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic st_t rand_state();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic void model_reset();
    hist.delete();
    fut.delete();
    hist.push_back(RV);
  endfunction

  function automatic exp_t model_step(bit en, logic [1:0] c, st_t ld, st_t pd);
    exp_t e;
    st_t  t;
    e.err = 1'b0;
    if (en) begin
      case (c)
        CMD_LOAD: begin
          hist.delete();
          fut.delete();
          hist.push_back(ld);
        end
        CMD_PUSH: begin
          hist.push_back(pd);
          if (hist.size() > DEPTH + 1) t = hist.pop_front();
          fut.delete();
        end
        CMD_UNDO: begin
          if (hist.size() > 1) begin
            t = hist.pop_back();
`ifdef GAME_UNDO_REDO_EN
            fut.push_back(t);
`endif
          end else begin
            e.err = 1'b1;
          end
        end
        default: begin
`ifdef GAME_UNDO_REDO_EN
          if (fut.size() > 0) hist.push_back(fut.pop_back());
          else e.err = 1'b1;
`endif
        end
      endcase
    end
    e.st = hist[$];
    e.uc = hist.size() - 1;
    e.rc = fut.size();
    return e;
  endfunction

  task automatic issue(input bit en, input logic [1:0] c, input st_t d);
    @(negedge clk);
    cmd_en    = en;
    cmd       = c;
    load_data = d;
    push_data = d;
    sb.push_back(model_step(en, c, d, d));
  endtask

  // Monitor: every cycle following an issued command, compare the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state_out", state_out, e.st);
        chk("undo_cnt", st_t'(undo_cnt), st_t'(e.uc));
        chk("redo_cnt", st_t'(redo_cnt), st_t'(e.rc));
        chk("cmd_err", st_t'(cmd_err), st_t'(e.err));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"}, state_out, RV);
    chk({tag, "_undo"}, st_t'(undo_cnt), '0);
    chk({tag, "_redo"}, st_t'(redo_cnt), '0);
    chk({tag, "_err"}, st_t'(cmd_err), '0);
    for (int i = 0; i <= int'(DEPTH); i++) chk({tag, "_ring"}, dut.ring_q[i], RV);
  endtask

  initial begin
    int unsigned r;
    logic [1:0]  c;
    rst_n     = 1'b0;
    cmd_en    = 1'b0;
    cmd       = 2'd0;
    load_data = '0;
    push_data = '0;
    model_reset();
    #3;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic load / push / undo down to rejection
    issue(1, CMD_LOAD, st_t'(1));
    issue(1, CMD_PUSH, st_t'(2));
    issue(1, CMD_PUSH, st_t'(3));
    repeat (3) issue(1, CMD_UNDO, '0);
    issue(0, CMD_UNDO, '0);

    // Saturation at DEPTH: the loaded state falls off the ring
    issue(1, CMD_LOAD, st_t'('h10));
    for (int i = 1; i <= 4; i++) issue(1, CMD_PUSH, st_t'('h10 + i));
    repeat (4) issue(1, CMD_UNDO, '0);
    issue(0, CMD_LOAD, '0);

`ifdef GAME_UNDO_REDO_EN
    issue(1, CMD_LOAD, st_t'('hA));
    issue(1, CMD_PUSH, st_t'('hB));
    issue(1, CMD_PUSH, st_t'('hC));
    repeat (2) issue(1, CMD_UNDO, '0);
    issue(1, CMD_REDO, '0);
    issue(1, CMD_PUSH, st_t'('hF));
    issue(1, CMD_REDO, '0);
    issue(0, CMD_REDO, '0);
`else
    issue(1, CMD_LOAD, st_t'('hA));
    issue(1, CMD_PUSH, st_t'('hB));
    issue(1, CMD_REDO, '0);
    issue(1, CMD_UNDO, '0);
    issue(1, CMD_REDO, '0);
`endif

    // Random mix that wraps the pointer repeatedly
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(99);
      if (r < 40) c = CMD_PUSH;
      else if (r < 75) c = CMD_UNDO;
      else if (r < 90) c = CMD_REDO;
      else c = CMD_LOAD;
      issue(($urandom_range(9) != 0), c, rand_state());
      if (n == 150) begin
        issue(0, 2'($urandom), rand_state());
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Idle with random command and data: everything must hold
    for (int n = 0; n < 20; n++) issue(0, 2'($urandom), rand_state());

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
